// File: rtl/note_classifier.sv
// Tuner classification stage: nearest open-string search over a 6-entry table with one subtractor.
// Optional NOTE_AVG_EN adds a 4-sample moving average ahead of the scan.
module note_classifier #(
  parameter int unsigned TOL         = 5,
  parameter int unsigned MIN_FREQ    = 600,
  parameter int unsigned MAX_FREQ    = 4000,
  parameter int unsigned TIMEOUT_CYC = 1024000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freq_valid,
  input  logic [13:0] freq_x10,
  output logic        busy,
  output logic        result_valid,
  output logic [9:0]  deviation,
  output logic [2:0]  note,
  output logic [2:0]  status
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);
  localparam logic signed [14:0] TolS = 15'(TOL);

`ifdef NOTE_AVG_EN
  typedef enum logic [1:0] {StIdle, StAvg, StScan, StResult} state_e;
`else
  typedef enum logic [1:0] {StIdle, StScan, StResult} state_e;
`endif

  state_e            state_q, state_d;
  logic [13:0]       sample_q, sample_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        best_idx_q, best_idx_d;
  logic [14:0]       best_diff_q, best_diff_d;
  logic              oor_q, oor_d;
  logic [9:0]        dev_q, dev_d;
  logic [2:0]        note_q, note_d;
  logic [2:0]        status_q, status_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [2:0]        tgt_sel;
  logic [13:0]       tgt;
  logic signed [14:0] delta;
  logic [14:0]       abs_diff;
  logic signed [9:0] dev_clamp;
  logic              in_range;
  logic              timeout_hit;

`ifdef NOTE_AVG_EN
  logic [13:0] buf_q [4];
  logic [13:0] buf_d [4];
  logic [2:0]  fill_q, fill_d;
  logic [15:0] sum;
`endif

  function automatic logic [13:0] target(input logic [2:0] i);
    case (i)
      3'd0:    target = 14'd824;
      3'd1:    target = 14'd1100;
      3'd2:    target = 14'd1468;
      3'd3:    target = 14'd1960;
      3'd4:    target = 14'd2469;
      default: target = 14'd3296;
    endcase
  endfunction

  // The scan and the final deviation share one subtractor.
  always_comb begin
    tgt_sel  = (state_q == StResult) ? best_idx_q : idx_q;
    tgt      = target(tgt_sel);
    delta    = $signed({1'b0, sample_q}) - $signed({1'b0, tgt});
    abs_diff = delta[14] ? $unsigned(-delta) : $unsigned(delta);
    if (delta > 15'sd511) begin
      dev_clamp = 10'sd511;
    end else if (delta < -15'sd511) begin
      dev_clamp = -10'sd511;
    end else begin
      dev_clamp = delta[9:0];
    end
    in_range = (freq_x10 >= 14'(MIN_FREQ)) && (freq_x10 <= 14'(MAX_FREQ));
  end

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_diff_d = best_diff_q;
    oor_d       = oor_q;
    dev_d       = dev_q;
    note_d      = note_q;
    status_d    = status_q;
    valid_d     = 1'b0;
    cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
`ifdef NOTE_AVG_EN
    buf_d  = buf_q;
    fill_d = fill_q;
    sum    = 16'(buf_q[0]) + 16'(buf_q[1]) + 16'(buf_q[2]) + 16'(buf_q[3]);
`endif

    // A result in the same cycle wins over the timeout blanking.
    timeout_hit = (cnt_q != CntMax) && (cnt_d == CntMax) && (state_q != StResult);
    if (timeout_hit) begin
      dev_d    = '0;
      note_d   = 3'd7;
      status_d = 3'd0;
`ifdef NOTE_AVG_EN
      fill_d   = '0;
`endif
    end

    unique case (state_q)
      StIdle: begin
        if (freq_valid) begin
          sample_d    = freq_x10;
          idx_d       = '0;
          best_idx_d  = '0;
          best_diff_d = '1;
          oor_d       = !in_range;
          if (!in_range) begin
            state_d = StResult;
`ifdef NOTE_AVG_EN
            fill_d  = '0;
`endif
          end else begin
`ifdef NOTE_AVG_EN
            buf_d[0] = freq_x10;
            buf_d[1] = buf_q[0];
            buf_d[2] = buf_q[1];
            buf_d[3] = buf_q[2];
            fill_d   = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            state_d  = StAvg;
`else
            state_d  = StScan;
`endif
          end
        end
      end
`ifdef NOTE_AVG_EN
      StAvg: begin
        if (fill_q == 3'd4) begin
          sample_d = sum[15:2];
        end
        state_d = StScan;
      end
`endif
      StScan: begin
        // Strict compare keeps the lower index on a tie.
        if (abs_diff < best_diff_q) begin
          best_diff_d = abs_diff;
          best_idx_d  = idx_q;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd5) begin
          state_d = StResult;
        end
      end
      StResult: begin
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
        if (oor_q) begin
          dev_d    = '0;
          note_d   = 3'd7;
          status_d = 3'd0;
        end else begin
          dev_d  = dev_clamp;
          note_d = best_idx_q;
          if (delta < -TolS) begin
            status_d = 3'd1;
          end else if (delta > TolS) begin
            status_d = 3'd3;
          end else begin
            status_d = 3'd2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sample_q    <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_diff_q <= '1;
      oor_q       <= 1'b0;
      dev_q       <= '0;
      note_q      <= 3'd7;
      status_q    <= 3'd0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
`ifdef NOTE_AVG_EN
      buf_q       <= '{default: '0};
      fill_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_diff_q <= best_diff_d;
      oor_q       <= oor_d;
      dev_q       <= dev_d;
      note_q      <= note_d;
      status_q    <= status_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
`ifdef NOTE_AVG_EN
      buf_q       <= buf_d;
      fill_q      <= fill_d;
`endif
    end
  end

  assign busy         = (state_q != StIdle);
  assign result_valid = valid_q;
  assign deviation    = dev_q;
  assign note         = note_q;
  assign status       = status_q;

endmodule

// File: tb/tb_note_classifier.sv
// Self-checking bench for note_classifier (default build) against a nearest-string reference model.
module tb_note_classifier;

  localparam int unsigned TCYC = 300;

  logic        clk;
  logic        rst_n;
  logic        freq_valid;
  logic [13:0] freq_x10;
  logic        busy;
  logic        result_valid;
  logic [9:0]  deviation;
  logic [2:0]  note;
  logic [2:0]  status;

  int errors = 0;
  int checks = 0;

  note_classifier #(
    .TOL(5), .MIN_FREQ(600), .MAX_FREQ(4000), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freq_valid(freq_valid), .freq_x10(freq_x10),
    .busy(busy), .result_valid(result_valid), .deviation(deviation),
    .note(note), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: nearest target by plain search, first minimum wins.
  task automatic model(input int f, output int e_note, output int e_dev, output int e_stat,
                       output int e_lat);
    int tbl [6] = '{824, 1100, 1468, 1960, 2469, 3296};
    int best, bd, d;
    if (f < 600 || f > 4000) begin
      e_note = 7; e_dev = 0; e_stat = 0; e_lat = 1;
      return;
    end
    best = 0; bd = 1 << 20;
    for (int i = 0; i < 6; i++) begin
      d = (f > tbl[i]) ? f - tbl[i] : tbl[i] - f;
      if (d < bd) begin bd = d; best = i; end
    end
    d = f - tbl[best];
    if (d > 511) d = 511;
    if (d < -511) d = -511;
    e_note = best; e_dev = d;
    e_stat = (d < -5) ? 1 : (d > 5) ? 3 : 2;
    e_lat = 7;
  endtask

  task automatic check_out(input string name, input int e_note, input int e_dev, input int e_stat);
    logic [9:0] ed;
    ed = 10'(e_dev);
    checks++;
    if (note !== 3'(e_note)) begin
      errors++; $display("FAIL %s note: got %0d want %0d", name, note, e_note);
    end
    checks++;
    if (deviation !== ed) begin
      errors++; $display("FAIL %s deviation: got %0d want %0d", name, $signed(deviation), e_dev);
    end
    checks++;
    if (status !== 3'(e_stat)) begin
      errors++; $display("FAIL %s status: got %0d want %0d", name, status, e_stat);
    end
  endtask

  task automatic wait_result(input string name, input int e_lat, input int start);
    int lat;
    lat = 0;
    for (int c = start; c <= 20; c++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat != e_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, e_lat);
    end
  endtask

  task automatic run_sample(input int f, input string name);
    int en, ed, es, el;
    model(f, en, ed, es, el);
    freq_x10 = 14'(f); freq_valid = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0; freq_x10 = 14'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy after capture: got %b want 1", name, busy);
    end
    wait_result(name, el, 1);
    check_out(name, en, ed, es);
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freq_valid = 1'b0; freq_x10 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL reset busy/valid: got %b/%b want 0/0", busy, result_valid);
    end
    check_out("reset", 7, 0, 0);
  endtask

  task automatic test_directed();
    int vals [13] = '{1100, 1460, 1284, 3900, 500, 824, 600, 599, 4000, 4001, 0, 962, 3296};
    foreach (vals[i]) run_sample(vals[i], $sformatf("directed_%0d", vals[i]));
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int f;
      f = int'($urandom_range(4300, 400));
      run_sample(f, $sformatf("random_%0d", f));
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_drop();
    int n;
    freq_x10 = 14'd1100; freq_valid = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 freq_x10 = 14'd2000; freq_valid = 1'b1;
    @(posedge clk); #1 freq_valid = 1'b0;
    wait_result("drop", 7, 4);
    check_out("drop", 1, 0, 2);
    count_strobes(15, n);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL drop extra strobes: got %0d want 0", n);
    end
  endtask

  task automatic test_back_to_back();
    run_sample(1960, "b2b_a");
    run_sample(2469, "b2b_b");
    run_sample(3000, "b2b_c");
  endtask

  task automatic test_timeout();
    int n1, n2;
    run_sample(1465, "timeout_pre");
    count_strobes(TCYC - 3, n1);
    check_out("timeout_before", 2, -3, 2);
    count_strobes(5, n2);
    check_out("timeout_after", 7, 0, 0);
    checks++;
    if (n1 + n2 != 0) begin
      errors++; $display("FAIL timeout strobes: got %0d want 0", n1 + n2);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    run_sample(2480, "midreset_pre");
    freq_x10 = 14'd1100; freq_valid = 1'b1;
    @(posedge clk); #1 freq_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL midreset busy/valid: got %b/%b want 0/0", busy, result_valid);
    end
    check_out("midreset", 7, 0, 0);
    count_strobes(12, n);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL midreset strobes: got %0d want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
